dotmatrix_scanner: RTL
======================

// Module: dotmatrix_scanner
// PURPOSE
//  Parametrised row/column scan driver for shift-register LED dot-matrix panels.
//  Holds a double-buffered 1-bit framebuffer of ROWS x COLS pixels; the game logic writes whole rows into the back bank.
//  A swap to the back bank happens only on a frame boundary, so frames never tear.
//  Per line: blanks the panel, shifts column data, latches it, advances the walking-zero row select, then shows the line with PWM brightness.
// PARAMETERS
//  ROWS           16  panel rows (>=2)
//  COLS           16  panel columns (>=2)
//  DWELL_W        12  line display window = 2**DWELL_W clk cycles
//  BRIGHT_W        4  brightness control width
//  ROW_PAIR_SWAP   1  1: physical data row = r^1 (dotmatrix v01 wiring fix); 0: data row = r
// PORTS
//  clk          in   1                 system clock, 12 MHz
//  reset        in   1                 synchronous, active-high
//  wr_en        in   1                 write wr_data into back bank row wr_row
//  wr_row       in   $clog2(ROWS)      row address
//  wr_data      in   COLS              pixel row, bit COLS-1 = leftmost column
//  swap_req     in   1                 request front/back swap at next frame boundary
//  brightness   in   BRIGHT_W          0 = dark, 2**BRIGHT_W-1 = max
//  swap_ack     out  1                 1-cycle pulse when the swap has taken effect
//  frame_start  out  1                 1-cycle pulse at start of each frame
//  rclk, rsdi   out  1                 row shift-register clock / data (rsdi active-low select)
//  cclk, csdi   out  1                 column shift-register clock / data
//  le           out  1                 column latch enable
//  oeb          out  1                 output enable, active-low
// BEHAVIOUR
//  - Timing constants: BASE = 2*COLS+2 and LINE = BASE + 2**DWELL_W cycles. The line counter lt runs 0..LINE-1 and the row counter r runs 0..ROWS-1.
//    Both wrap, and a frame is ROWS*LINE cycles.
//  - Output timing: all outputs are registered. The value for counter state (r,lt) appears one cycle later. The counter is 0 in the first cycle after reset.
//  - Shift window, lt < 2*COLS: k = lt>>1 and p = physical row.
//    On even lt, csdi = front[p][COLS-1-k] and cclk = 0. On odd lt, cclk = 1.
//    This gives exactly COLS rising cclk edges per line, MSB first.
//  - Latch and row step, lt = 2*COLS: rsdi = (r != 0), rclk = 0, cclk = 0.
//  - Latch and row step, lt = 2*COLS+1: rclk = 1 and le = 1. rclk and le are 0 at all other lt values.
//  - Display window: d = lt-BASE. oeb = 0 iff lt >= BASE and d[DWELL_W-1 -: BRIGHT_W] < brightness; otherwise oeb = 1.
//    oeb is 1 throughout the shift and latch cycles.
//    brightness is sampled continuously, so a change takes effect within a line.
//  - Write port: a write lands in the back bank the cycle after wr_en. Writes with wr_row >= ROWS are ignored. The front bank is read-only to the port.
//  - swap_req: a 1-cycle pulse sets a pending flag. Extra requests while pending are merged into one.
//  - Swap point: at the last frame cycle (r = ROWS-1, lt = LINE-1) with pending set, the front/back banks exchange and pending clears.
//    swap_ack then pulses in the same cycle as the next frame_start.
//    The new front bank is displayed from row 0 of that frame.
//  - Simultaneous events: a write in the swap cycle goes to the pre-swap back bank, which becomes the new front bank.
//    A swap_req in the swap cycle is held pending for the next frame.
//  - Back bank after swap: the new back bank holds the previous front contents; it is not copied or cleared.
//  - Reset values: lt = 0, r = 0, front = bank 0, pending = 0, rclk = 0, rsdi = 1, cclk = 0, csdi = 0, le = 0, oeb = 1, swap_ack = 0, frame_start = 0.
//  - Framebuffer contents are unaffected by reset.
//  - Reset mid-line aborts the scan, and the panel is blanked in the next cycle.
//  - frame_start pulses when state (0,0) is output, including the first cycle after reset.
// TESTING (ROWS=4, COLS=4, DWELL_W=4, BRIGHT_W=2, ROW_PAIR_SWAP=1 => BASE=10, LINE=26, frame=104)
//  1. Reset held for 3 cycles -> all outputs at reset values, oeb=1, rsdi=1. After release, frame_start fires on the first cycle, then every 104 cycles.
//  2. Write row1=4'b1010, row0=4'b0110, then swap_req. Expect swap_ack together with the next frame_start.
//     Line r=0 then shifts csdi 1,0,1,0 (p=1) with 4 cclk edges and le high one cycle at lt=9. Line r=1 shifts 0,1,1,0.
//  3. Row walk -> 4 rclk pulses per frame. rsdi=0 is sampled only at the r=0 pulse and is 1 at r=1..3.
//  4. Brightness 0 -> oeb stays 1 for a full frame. Brightness 1 -> 4 low cycles per line. Brightness 3 -> 12 low cycles per line (lt 10..21).
//  5. Writes without swap_req -> display unchanged. Three swap_req pulses in one frame -> exactly one swap_ack.
//     wr_row in range with wr_en=0 -> no change to either bank.
//  6. Reset asserted at lt=5 of r=2 -> oeb=1, le=0, next frame_start one cycle after release. Framebuffer data is still displayed after release.

Source files
------------

// File: rtl/dotmatrix_if.sv
// Bus between the game logic (master) and the dot-matrix scan driver (slave).
//   master drives: wr_en, wr_row, wr_data, swap_req, brightness
//   slave drives : swap_ack, frame_start and the panel pins
//                  rclk/rsdi (row shifter), cclk/csdi (column shifter), le, oeb
interface dotmatrix_if #(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int BRIGHT_W = 4
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                wr_en;
    logic [RW-1:0]       wr_row;
    logic [COLS-1:0]     wr_data;
    logic                swap_req;
    logic [BRIGHT_W-1:0] brightness;

    logic                swap_ack;
    logic                frame_start;
    logic                rclk;
    logic                rsdi;
    logic                cclk;
    logic                csdi;
    logic                le;
    logic                oeb;

    modport master (
        output wr_en, wr_row, wr_data, swap_req, brightness,
        input  swap_ack, frame_start, rclk, rsdi, cclk, csdi, le, oeb
    );

    modport slave (
        input  wr_en, wr_row, wr_data, swap_req, brightness,
        output swap_ack, frame_start, rclk, rsdi, cclk, csdi, le, oeb
    );
endinterface

// File: rtl/dotmatrix_scanner.sv
// Row/column scan driver for shift-register LED dot-matrix panels.
// Double-buffered ROWS x COLS 1-bit framebuffer; the game logic writes rows
// into the back bank and requests a swap, which is applied only at the frame
// boundary so frames never tear.
// Per line: shift COLS column bits (MSB = leftmost first), latch them while
// stepping the walking-zero row select, then display with PWM brightness.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high
//   bus    - dotmatrix_if.slave: write port, swap handshake, brightness,
//            frame/swap pulses and panel pins (all outputs registered)
module dotmatrix_scanner #(
    parameter int ROWS          = 16,
    parameter int COLS          = 16,
    parameter int DWELL_W       = 12,
    parameter int BRIGHT_W      = 4,
    parameter int ROW_PAIR_SWAP = 1
) (
    input  logic       clk,
    input  logic       reset,
    dotmatrix_if.slave bus
);
    localparam int BASE = 2 * COLS + 2;
    localparam int LINE = BASE + (1 << DWELL_W);
    localparam int LT_W = $clog2(LINE);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

    // scan counters and bank control
    logic [LT_W-1:0] lt_q, lt_d;
    logic [RW-1:0]   r_q, r_d;
    logic            front_q, front_d;
    logic            pend_q, pend_d;
    logic            swp_q, swp_d;

    // framebuffer: [bank][row][col], no reset so contents survive a reset
    logic [1:0][ROWS-1:0][COLS-1:0] fb_q;

    // registered outputs
    logic rclk_q, rclk_d;
    logic rsdi_q, rsdi_d;
    logic cclk_q, cclk_d;
    logic csdi_q, csdi_d;
    logic le_q, le_d;
    logic oeb_q, oeb_d;
    logic ack_q, ack_d;
    logic fs_q, fs_d;

    logic                last_lt, last_row, do_swap;
    logic [RW-1:0]       p;
    logic [CW-1:0]       col;
    logic [BRIGHT_W-1:0] dtop;

    always_comb begin
        last_lt  = (lt_q == LT_W'(LINE - 1));
        last_row = (r_q == RW'(ROWS - 1));
        lt_d     = last_lt ? '0 : lt_q + 1'b1;
        r_d      = r_q;
        if (last_lt)
            r_d = last_row ? '0 : r_q + 1'b1;

        // swap only on the last cycle of a frame; a request arriving in that
        // same cycle stays pending for the following frame
        do_swap = pend_q && last_lt && last_row;
        pend_d  = do_swap ? bus.swap_req : (pend_q | bus.swap_req);
        front_d = front_q ^ do_swap;
        swp_d   = do_swap;

        // row-pair wiring fix; an unpaired last row (odd ROWS) maps to itself
        p = r_q;
        if (ROW_PAIR_SWAP != 0 && ((32'(r_q) ^ 32'd1) < ROWS))
            p = r_q ^ RW'(1);

        col  = CW'(COLS - 1) - CW'(lt_q >> 1);
        // top BRIGHT_W bits of the display-window offset drive the PWM compare
        dtop = BRIGHT_W'((lt_q - LT_W'(BASE)) >> (DWELL_W - BRIGHT_W));

        rclk_d = 1'b0;
        cclk_d = 1'b0;
        le_d   = 1'b0;
        oeb_d  = 1'b1;
        rsdi_d = rsdi_q;
        csdi_d = csdi_q;
        if (lt_q < LT_W'(2 * COLS)) begin
            // data set up on even cycles, clocked in on odd cycles
            if (lt_q[0])
                cclk_d = 1'b1;
            else
                csdi_d = fb_q[front_q][p][col];
        end else if (lt_q == LT_W'(2 * COLS)) begin
            // walking zero: a 0 enters the row shifter only at row 0
            rsdi_d = (r_q != '0);
        end else if (lt_q == LT_W'(2 * COLS + 1)) begin
            rclk_d = 1'b1;
            le_d   = 1'b1;
        end else begin
            oeb_d = !(dtop < bus.brightness);
        end

        fs_d  = (r_q == '0) && (lt_q == '0);
        ack_d = swp_q;  // lands together with the next frame_start
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lt_q    <= '0;
            r_q     <= '0;
            front_q <= 1'b0;
            pend_q  <= 1'b0;
            swp_q   <= 1'b0;
            rclk_q  <= 1'b0;
            rsdi_q  <= 1'b1;
            cclk_q  <= 1'b0;
            csdi_q  <= 1'b0;
            le_q    <= 1'b0;
            oeb_q   <= 1'b1;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            lt_q    <= lt_d;
            r_q     <= r_d;
            front_q <= front_d;
            pend_q  <= pend_d;
            swp_q   <= swp_d;
            rclk_q  <= rclk_d;
            rsdi_q  <= rsdi_d;
            cclk_q  <= cclk_d;
            csdi_q  <= csdi_d;
            le_q    <= le_d;
            oeb_q   <= oeb_d;
            ack_q   <= ack_d;
            fs_q    <= fs_d;
        end
    end

    // writes always target the current back bank; in the swap cycle that is
    // the bank becoming front, so the write shows up in the new frame
    always_ff @(posedge clk) begin
        if (bus.wr_en && (32'(bus.wr_row) < ROWS))
            fb_q[~front_q][bus.wr_row] <= bus.wr_data;
    end

    assign bus.rclk        = rclk_q;
    assign bus.rsdi        = rsdi_q;
    assign bus.cclk        = cclk_q;
    assign bus.csdi        = csdi_q;
    assign bus.le          = le_q;
    assign bus.oeb         = oeb_q;
    assign bus.swap_ack    = ack_q;
    assign bus.frame_start = fs_q;
endmodule
